// File: rtl/pll_reset_sequencer_if.sv
// ----------------------------------------------------------------------------
// pll_reset_sequencer_if
// Groups the PLL-facing and reset-facing signals of the PLL reset sequencer.
//   i_pll_locked   PLL LOCKED (asynchronous to the sequencer clock)
//   i_soft_rst     synchronous request to restart the PLL bring-up
//   o_pll_reset    active-high reset to the PLL RST pin
//   o_rst_n        active-low reset to downstream logic (1 = run)
//   o_retry_count  lock timeouts since power-on reset, saturating at 255
//   o_state        one-hot state {RUN, STABLE, WAIT_LOCK, PLL_RESET}
// master: the sequencer side (drives the resets).
// slave : the environment side (drives lock / soft reset, observes resets).
// ----------------------------------------------------------------------------
interface pll_reset_sequencer_if;
  logic       i_pll_locked;
  logic       i_soft_rst;
  logic       o_pll_reset;
  logic       o_rst_n;
  logic [7:0] o_retry_count;
  logic [3:0] o_state;

  modport master (
    input  i_pll_locked,
    input  i_soft_rst,
    output o_pll_reset,
    output o_rst_n,
    output o_retry_count,
    output o_state
  );

  modport slave (
    output i_pll_locked,
    output i_soft_rst,
    input  o_pll_reset,
    input  o_rst_n,
    input  o_retry_count,
    input  o_state
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// ----------------------------------------------------------------------------
// pll_reset_sequencer
// Owns PLL bring-up: holds the PLL in reset for a fixed interval, waits for
// LOCKED with a timeout/retry, requires LOCKED to stay high for a programmable
// interval, then releases a glitch-free active-low reset downstream.
// Ports:
//   i_clk    free-running board reference clock (the PLL input, never a PLL output)
//   i_rst_n  asynchronous active-low reset
//   bus      pll_reset_sequencer_if.master (lock/soft-reset in, resets/status out)
// ----------------------------------------------------------------------------
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65535,
  parameter int STABLE_CYCLES  = 1024,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  pll_reset_sequencer_if.master        bus
);

  localparam int MAX_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_C  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CNT_W  = $clog2(MAX_C + 1);

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  // Bit order matches o_state: {RUN, STABLE, WAIT_LOCK, PLL_RESET}.
  typedef enum logic [3:0] {
    S_PLL_RESET = 4'b0001,
    S_WAIT_LOCK = 4'b0010,
    S_STABLE    = 4'b0100,
    S_RUN       = 4'b1000
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [7:0]             retry_q, retry_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   lock_sync;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // LOCKED crosses from the PLL domain; only the last synchronizer stage is used.
  assign lock_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], bus.i_pll_locked};
  end

  // Priority: soft reset, then lock loss, then counter expiry.
  // Every state change clears the shared counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    if (bus.i_soft_rst) begin
      state_d = S_PLL_RESET;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_PLL_RESET: begin
          if (cnt_q == PLL_RST_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_WAIT_LOCK: begin
          if (lock_sync) begin
            state_d = S_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == LOCK_LAST) begin
            state_d = S_PLL_RESET;
            cnt_d   = '0;
            retry_d = sat_inc8(retry_q);
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_STABLE: begin
          if (!lock_sync) begin
            state_d = S_PLL_RESET;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_RUN: begin
          cnt_d = '0;
          if (!lock_sync) state_d = S_PLL_RESET;
        end
        default: begin
          state_d = S_PLL_RESET;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_PLL_RESET;
      cnt_q   <= '0;
      retry_q <= 8'd0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      sync_q  <= sync_d;
    end
  end

  // Resets come straight from state flops: no decode, so no glitches.
  assign bus.o_pll_reset   = state_q[0];
  assign bus.o_rst_n       = state_q[3];
  assign bus.o_retry_count = retry_q;
  assign bus.o_state       = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pll_reset_sequencer
// Segment table of {cycle count, locked, soft reset, expected state, expected
// retry count}. Each driven cycle pushes its expected outputs to a queue, which
// is popped and compared one edge later. Asynchronous reset cases are checked
// by hand between tables.
// ----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

  localparam logic [3:0] PR = 4'b0001;
  localparam logic [3:0] WL = 4'b0010;
  localparam logic [3:0] ST = 4'b0100;
  localparam logic [3:0] RN = 4'b1000;

  logic clk;
  logic rst_n;

  pll_reset_sequencer_if bus ();

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .SYNC_STAGES   (2)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int         n;
    logic       lk;
    logic       sr;
    logic [3:0] st;
    logic [7:0] rc;
  } seg_t;

  typedef struct {
    logic [3:0] st;
    logic [7:0] rc;
  } exp_t;

  seg_t tbl[$];
  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [7:0] sat8(input int v);
    return (v > 255) ? 8'd255 : 8'(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic add(input int n, input logic lk, input logic sr,
                     input logic [3:0] st, input logic [7:0] rc);
    seg_t s;
    s.n = n; s.lk = lk; s.sr = sr; s.st = st; s.rc = rc;
    tbl.push_back(s);
  endtask

  task automatic check_outputs();
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_underflow at %0t", $time);
      return;
    end
    e = sbq.pop_front();
    chk("o_state",       bus.o_state,       e.st);
    chk("o_pll_reset",   bus.o_pll_reset,   e.st[0]);
    chk("o_rst_n",       bus.o_rst_n,       e.st[3]);
    chk("o_retry_count", bus.o_retry_count, e.rc);
  endtask

  // Called at 1 time unit after a rising edge; returns at the same phase.
  task automatic run_table();
    exp_t e;
    foreach (tbl[i]) begin
      for (int c = 0; c < tbl[i].n; c++) begin
        bus.i_pll_locked = tbl[i].lk;
        bus.i_soft_rst   = tbl[i].sr;
        e.st = tbl[i].st;
        e.rc = tbl[i].rc;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        check_outputs();
      end
    end
    tbl.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"},   bus.o_state,       PR);
    chk({tag, "_pll_rst"}, bus.o_pll_reset,   1'b1);
    chk({tag, "_rst_n"},   bus.o_rst_n,       1'b0);
    chk({tag, "_retry"},   bus.o_retry_count, 8'd0);
  endtask

  // Asserts reset between edges and checks outputs before any edge arrives.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    @(posedge clk);
    #1;
    check_reset_outputs({tag, "_held"});
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.i_pll_locked = 1'b0;
    bus.i_soft_rst   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;

    // Clean bring-up: 4 reset cycles, lock raised 10 cycles after reset falls.
    add(3, 0, 0, PR, 0); add(10, 0, 0, WL, 0); add(2, 1, 0, WL, 0);
    add(8, 1, 0, ST, 0); add(4, 1, 0, RN, 0);
    // Lock loss in RUN, then full re-lock.
    add(2, 0, 0, RN, 0); add(4, 0, 0, PR, 0); add(1, 0, 0, WL, 0);
    add(2, 1, 0, WL, 0); add(8, 1, 0, ST, 0); add(2, 1, 0, RN, 0);
    // Soft reset in RUN; then a 3-cycle lock drop around STABLE count 5.
    add(1, 1, 1, PR, 0); add(3, 1, 0, PR, 0); add(1, 1, 0, WL, 0);
    add(5, 1, 0, ST, 0); add(2, 0, 0, ST, 0); add(1, 0, 0, PR, 0);
    add(3, 1, 0, PR, 0); add(1, 1, 0, WL, 0); add(8, 1, 0, ST, 0);
    add(2, 1, 0, RN, 0);
    // Soft reset on the timeout edge (no increment), then held for a while.
    add(2, 0, 0, RN, 0); add(4, 0, 0, PR, 0); add(20, 0, 0, WL, 0);
    add(6, 0, 1, PR, 0); add(3, 0, 0, PR, 0);
    // Lock never arrives: retry count climbs and saturates at 255.
    for (int k = 0; k < 260; k++) begin
      add(20, 0, 0, WL, sat8(k));
      add(4, 0, 0, PR, sat8(k + 1));
    end
    // Lock arrives, stop partway through STABLE.
    add(2, 1, 0, WL, 255); add(3, 1, 0, ST, 255);
    run_table();

    async_reset("rst_mid_stable");

    // Lock already high when reset releases.
    add(3, 1, 0, PR, 0); add(1, 1, 0, WL, 0); add(8, 1, 0, ST, 0);
    add(2, 1, 0, RN, 0);
    run_table();

    async_reset("rst_mid_run");

    chk("scoreboard_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
